// File: rtl/cpu_ctrl_wait_pkg.sv
// rtl/cpu_ctrl_wait_pkg.sv - shared states and encodings for the wait-capable CPU controller
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE,
    S_GETA, S_GETB, S_ALU_MOV, S_ALU, S_ALU_CMP, S_ALU_ADDR,
    S_GETADDR, S_LOADB, S_UPDDP, S_MEM_RD, S_MEM_WR,
    S_WR_IMM, S_WR_C, S_WR_MEM, S_LINK,
    S_BR_T, S_BR_NT, S_BR_X, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_LINK = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_B       = 2'b00;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;
  localparam logic [1:0] OP_BL      = 2'b11;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;

  localparam logic [1:0] PC_ZERO = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

endpackage

// File: rtl/cpu_ctrl_wait_if.sv
// rtl/cpu_ctrl_wait_if.sv - controller <-> datapath/memory signal bundle
interface cpu_ctrl_wait_if #(
  parameter int ST_W = 5
);
  logic [2:0]      opcode;
  logic [1:0]      op;
  logic [2:0]      cond;
  logic            N, V, Z;
  logic            mem_ready;
  logic            run;
  logic [2:0]      nsel;
  logic [3:0]      vsel;
  logic            loada, loadb, loadc, loads, write, asel, bsel;
  logic            load_ir, load_addr, load_pc, addr_sel;
  logic [1:0]      pc_sel;
  logic [1:0]      mem_cmd;
  logic            halted;
  logic            bus_err;
  logic [1:0]      err_code;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode, op, cond, N, V, Z, mem_ready, run,
    output nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           load_ir, load_addr, load_pc, addr_sel, pc_sel, mem_cmd,
           halted, bus_err, err_code, state
  );

  modport slave (
    output opcode, op, cond, N, V, Z, mem_ready, run,
    input  nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
           load_ir, load_addr, load_pc, addr_sel, pc_sel, mem_cmd,
           halted, bus_err, err_code, state
  );
endinterface

// File: rtl/cpu_ctrl_wait_branch_cond_eval.sv
// rtl/cpu_ctrl_wait_branch_cond_eval.sv - conditional branch decision from cond field and flags
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_wait.sv
// rtl/cpu_ctrl_wait.sv - multi-cycle CPU control FSM with memory wait handshake and sticky errors
module cpu_ctrl_wait
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int ST_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  cpu_ctrl_wait_if.master  bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q;
  logic [1:0]       err_q, err_d;
  logic             br_taken, br_illegal;
  logic             in_wait, timeout;

  branch_cond_eval u_branch_cond_eval (
    .cond    (bus.cond),
    .n       (bus.N),
    .v       (bus.V),
    .z       (bus.Z),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  function automatic state_t decode_target(input logic [2:0] opc, input logic [1:0] o,
                                           input logic tk, input logic ill);
    state_t t;
    t = S_ERR;
    case (opc)
      OPC_MOV:          if (o == OP_MOV_IMM) t = S_WR_IMM;
                        else if (o == OP_MOV_REG) t = S_GETB;
      OPC_ALU:          t = (o == OP_MVN) ? S_GETB : S_GETA;
      OPC_LDR, OPC_STR: if (o == OP_MEM) t = S_GETA;
      OPC_B:            if (o == OP_B && !ill) t = tk ? S_BR_T : S_BR_NT;
      OPC_LINK:         if (o == OP_BX) t = S_BR_X;
                        else if (o == OP_BL || o == OP_BLX) t = S_LINK;
      OPC_HALT:         t = S_HALT;
      default:          t = S_ERR;
    endcase
    return t;
  endfunction

  // Ready on the final permitted cycle still completes the access.
  assign in_wait = (state_q == S_IF1) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = in_wait && !bus.mem_ready && (wait_q == CNT_W'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= (in_wait && !bus.mem_ready) ? wait_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_RST:      state_d = S_IF1;
      S_IF1:      if (bus.mem_ready) state_d = S_IF2;
      S_IF2:      state_d = S_UPDPC;
      S_UPDPC:    state_d = S_DECODE;
      S_DECODE: begin
        state_d = decode_target(bus.opcode, bus.op, br_taken, br_illegal);
        if (state_d == S_ERR) err_d = ERR_ILLEGAL;
      end
      S_GETA:     state_d = (bus.opcode == OPC_LDR || bus.opcode == OPC_STR) ? S_ALU_ADDR : S_GETB;
      S_GETB: begin
        if (bus.opcode != OPC_ALU || bus.op == OP_MVN) state_d = S_ALU_MOV;
        else if (bus.op == OP_CMP)                     state_d = S_ALU_CMP;
        else                                           state_d = S_ALU;
      end
      S_ALU_MOV, S_ALU:  state_d = S_WR_C;
      S_ALU_CMP:         state_d = S_IF1;
      S_ALU_ADDR:        state_d = S_GETADDR;
      S_GETADDR:         state_d = (bus.opcode == OPC_STR) ? S_LOADB : S_MEM_RD;
      S_LOADB:           state_d = S_UPDDP;
      S_UPDDP:           state_d = S_MEM_WR;
      S_MEM_RD:          if (bus.mem_ready) state_d = S_WR_MEM;
      S_MEM_WR:          if (bus.mem_ready) state_d = S_IF1;
      S_WR_IMM, S_WR_C, S_WR_MEM: state_d = S_IF1;
      S_LINK:            state_d = (bus.op == OP_BL) ? S_BR_T : S_BR_X;
      S_BR_T, S_BR_NT, S_BR_X:    state_d = S_IF1;
      S_HALT:            if (bus.run) state_d = S_IF1;
      S_ERR:             state_d = S_ERR;
      default:           state_d = S_RST;
    endcase
    if (timeout) begin
      state_d = S_ERR;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_comb begin
    bus.nsel      = NSEL_RD;
    bus.vsel      = 4'b0000;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.write     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_addr = 1'b0;
    bus.load_pc   = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.pc_sel    = PC_ZERO;
    bus.mem_cmd   = MEM_NONE;
    bus.halted    = 1'b0;
    bus.bus_err   = 1'b0;
    case (state_q)
      S_RST:      bus.load_pc = 1'b1;
      S_IF1:      begin bus.addr_sel = 1'b1; bus.mem_cmd = MREAD; end
      S_IF2:      begin bus.addr_sel = 1'b1; bus.mem_cmd = MREAD; bus.load_ir = 1'b1; end
      S_UPDPC:    begin bus.load_pc = 1'b1; bus.pc_sel = PC_INC; end
      S_GETA:     begin bus.loada = 1'b1; bus.nsel = NSEL_RN; end
      S_GETB:     begin bus.loadb = 1'b1; bus.nsel = NSEL_RM; end
      S_ALU_MOV:  begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_ALU:      bus.loadc = 1'b1;
      S_ALU_CMP:  bus.loads = 1'b1;
      S_ALU_ADDR: begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_GETADDR:  bus.load_addr = 1'b1;
      S_LOADB:    bus.loadb = 1'b1;
      S_UPDDP:    begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_MEM_RD:   bus.mem_cmd = MREAD;
      S_MEM_WR:   bus.mem_cmd = MWRITE;
      S_WR_IMM:   begin bus.nsel = NSEL_RN; bus.vsel = VSEL_SXIMM8; bus.write = 1'b1; end
      S_WR_C:     begin bus.vsel = VSEL_C; bus.write = 1'b1; end
      S_WR_MEM:   begin bus.vsel = VSEL_MDATA; bus.write = 1'b1; bus.mem_cmd = MREAD; end
      S_LINK:     begin bus.nsel = NSEL_RN; bus.vsel = VSEL_PC; bus.write = 1'b1; end
      S_BR_T:     begin bus.load_pc = 1'b1; bus.pc_sel = PC_REL; end
      S_BR_X:     begin bus.load_pc = 1'b1; bus.pc_sel = PC_REG; end
      S_HALT:     bus.halted = 1'b1;
      S_ERR:      bus.bus_err = 1'b1;
      default:    ;
    endcase
  end

  assign bus.err_code = err_q;
  assign bus.state    = ST_W'(state_q);

endmodule

// File: doc/cpu_ctrl_wait.md
Name: cpu_ctrl_wait

Overview:
Multi-cycle control FSM for the RISC CPU, successor to the fixed-latency controller. It adds variable-latency memory with a mem_ready handshake and a parametrised wait timeout. It also adds full conditional-branch evaluation (B/BEQ/BNE/BLT/BLE) and sticky error reporting for bus timeout and illegal instructions. It drives the datapath, PC, IR and data-address register from the IR-decoded opcode, op and cond fields plus the N/V/Z flags.

Parameters:
MEM_WAIT_MAX, 15, maximum cycles a memory access may wait for mem_ready before the bus-timeout error (must be >=1).
ST_W, 5, state register width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
cond  in  3  IR[10:8], branch condition
N, V, Z  in  1 each  status flags
mem_ready  in  1  memory completes the current access this cycle
run  in  1  resume from HALT
nsel  out  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm
vsel  out  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
loada, loadb, loadc, loads, write, asel, bsel  out  1 each  datapath controls
load_ir, load_addr, load_pc, addr_sel  out  1 each  fetch and address controls
pc_sel  out  2  next-PC select: 00 zero, 01 PC+1, 10 PC+sximm8, 11 Rd value
mem_cmd  out  2  00 none, 01 MREAD, 10 MWRITE
halted  out  1  in HALT
bus_err  out  1  in ERR
err_code  out  2  01 timeout, 10 illegal instruction, 00 none
state  out  ST_W  present state, for debug

Behaviour:
- Moore outputs decode the present state only. Transitions depend on opcode, op, cond, flags, mem_ready, run and the wait counter.
- Reset is synchronous: the next state is RST. Any output not listed for a state is 0, nsel is 010, and mem_cmd is 00.
  - RST outputs: load_pc=1, pc_sel=00, all else 0.
  - err_code is cleared to 00 only by reset.
- Fetch sequence:
  - RST -> IF1.
  - IF1: addr_sel=1, mem_cmd=01. Stay in IF1 while mem_ready=0.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1.
  - UPDPC: load_pc=1, pc_sel=01.
  - DECODE: routes to the instruction sequence.
  - Zero-wait fetch (mem_ready=1 on the first IF1 cycle) spends exactly 1 cycle in IF1.
- Wait counter, width $clog2(MEM_WAIT_MAX+1):
  - Cleared on entry to IF1 and MEM; increments each cycle mem_ready=0.
  - If it reaches MEM_WAIT_MAX with mem_ready=0, go to ERR with err_code=01.
  - mem_ready=1 on the same cycle the limit is reached means success; ready wins.
- ERR: bus_err=1, all other controls 0, mem_cmd 00. Only reset leaves ERR.
- Instruction sequences after DECODE:
  - MOV Rn,#imm (110 10): WRITEREG with nsel Rn, vsel sximm8, write=1.
  - MOV Rd,Rm (110 00) / MVN (101 11): GETB (loadb, nsel Rm) -> ALU (asel=1, loadc) -> WRITEREG (nsel Rd, vsel C, write).
  - ADD (101 00) / AND (101 10): GETA (loada, nsel Rn) -> GETB -> ALU (loadc) -> WRITEREG.
  - CMP (101 01): GETA -> GETB -> ALU (loads only) -> IF1.
  - LDR (011 00): GETA -> ALU (bsel=1, loadc) -> GETADDR (load_addr) -> MEM (addr_sel=0, mem_cmd=01, wait) -> WRITEREG (vsel mdata, nsel Rd, write, mem_cmd=01).
  - STR (100 00): GETA -> ALU (bsel=1, loadc) -> GETADDR -> LOADB (nsel Rd, loadb) -> UPDDP (asel=1, loadc) -> MEM (mem_cmd=10, wait) -> IF1.
  - B-family (001 00): BR -> IF1. Taken: load_pc=1, pc_sel=10. Not taken: load_pc=0.
    - cond 000 always; 001 Z; 010 !Z; 011 N^V; 100 (N^V)|Z; 101-111 illegal.
  - BL (010 11): LINK (write, vsel PC, nsel Rn) -> BR (load_pc, pc_sel=10, unconditional).
  - BX (010 00): BR with nsel Rd, load_pc, pc_sel=11.
  - BLX (010 10): LINK -> BR with pc_sel=11.
    - BLX with Rd equal to the link register jumps to the new link value (defined behaviour).
  - HALT (111 xx): HALT state, halted=1. Stays in HALT until run=1, then IF1. PC already points to the next instruction.
  - Any other opcode/op, or illegal cond: ERR with err_code=10.
- Reset mid-access: state becomes RST on the next edge and mem_cmd drops to 00 that cycle; no pending access is completed.
- PC arithmetic and wrap-around are the datapath's concern. The FSM only selects pc_sel.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum.
  - opcode/op constants.
  - MREAD/MWRITE.
  - pc_sel, nsel and vsel encodings.
  - err_code values.
  - cond encodings.
- Sub-module branch_cond_eval: combinational, (cond, N, V, Z) -> taken, illegal.

Test Plan:
- Reset, mem_ready=1 constantly -> states RST, IF1, IF2, UPDPC, DECODE on successive cycles; IF1 lasts 1 cycle; load_ir=1 only in IF2.
- MOV R0,#5 fetch with mem_ready low for 3 cycles -> IF1 held 4 cycles with mem_cmd=01 and addr_sel=1; then IF2; then WRITEREG with vsel=0100, nsel=100, write=1.
- MEM_WAIT_MAX=4, LDR with mem_ready=0 in MEM -> ERR after 4 wait cycles; bus_err=1, err_code=01; held for 10 cycles until reset.
- BLT (cond 011): N=1, V=0 -> BR load_pc=1, pc_sel=10. N=1, V=1 -> load_pc=0. Then IF1 in both cases.
- STR, zero-wait -> GETA, ALU, GETADDR, LOADB, UPDDP, MEM, IF1; mem_cmd=10 only in MEM.
- HALT then run=1 -> IF1 next cycle with halted=0. Opcode 000 -> ERR, err_code=10. Reset asserted during MEM -> RST next edge, mem_cmd=00.
